i2s_receiver: RTL

Receive-side I2S controller: the counterpart of the DAC path. It accepts an external I2S stream (bit clock, left/right select, serial data) from an ADC or codec, oversamples it in the system clock domain, and deserialises MSB-first, one-bit-delayed words into parallel left/right samples. It sits between the GPIO pins and the mixer/oscillator sample domain, delivering one stereo sample pair per LRCK frame with a single-cycle valid strobe.

---
 rtl/i2s_receiver.sv | 116 +++++++++++
 1 files changed

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S slave receiver delivering one stereo pair per LRCK frame
// Ports: clk (system clock), reset (sync, active-low), i2sBitClock / i2sLeftRightSelect /
//        i2sSoundData (async I2S pins), left_sample / right_sample (last completed words),
//        sample_valid (1-cycle strobe), short_frame (a channel had < DATA_WIDTH bits),
//        locked (a full frame decoded since reset or watchdog expiry)
module i2s_receiver #(
   parameter int DATA_WIDTH = 24,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i2sBitClock,
   input  logic                  i2sLeftRightSelect,
   input  logic                  i2sSoundData,
   output logic [DATA_WIDTH-1:0] left_sample,
   output logic [DATA_WIDTH-1:0] right_sample,
   output logic                  sample_valid,
   output logic                  short_frame,
   output logic                  locked
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
   localparam logic [DATA_WIDTH-1:0] TOP = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
   state_t state, state_n;
   logic [2:0] bclk_s;
   logic [1:0] lr_s, sd_s;
   logic lr_prev, left_short;
   logic [CW-1:0] cnt;
   logic [TW-1:0] wdog;
   logic [DATA_WIDTH-1:0] shreg, left_hold;
   logic bclk_rise, lr, sd, lr_edge, expired, latch_l, latch_r, clr, shift;
   assign bclk_rise = bclk_s[1] & ~bclk_s[2];
   assign lr        = lr_s[1];
   assign sd        = sd_s[1];
   assign lr_edge   = bclk_rise && (lr != lr_prev);
   // a bit-clock edge in the same cycle always wins over the watchdog
   assign expired   = !bclk_rise && (wdog == TMAX);
   always_ff @(posedge clk) begin
      if (!reset) state <= SYNC;
      else state <= state_n;
   end
   // the bit that reveals an LRCK edge still belongs to the previous slot, so it is never shifted
   always_comb begin
      state_n = state;
      latch_l = 1'b0;
      latch_r = 1'b0;
      clr     = 1'b0;
      shift   = 1'b0;
      case (state)
         SYNC: if (lr_edge && !lr) begin
            state_n = LEFT;
            clr     = 1'b1;
         end
         LEFT: if (lr_edge && lr) begin
            state_n = RIGHT;
            latch_l = 1'b1;
            clr     = 1'b1;
         end else shift = bclk_rise;
         RIGHT: if (lr_edge && !lr) begin
            state_n = LEFT;
            latch_r = 1'b1;
            clr     = 1'b1;
         end else shift = bclk_rise;
         default: state_n = SYNC;
      endcase
      if (expired) state_n = SYNC;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         bclk_s       <= '0;
         lr_s         <= '0;
         sd_s         <= '0;
         lr_prev      <= 1'b0;
         cnt          <= '0;
         wdog         <= '0;
         shreg        <= '0;
         left_hold    <= '0;
         left_short   <= 1'b0;
         left_sample  <= '0;
         right_sample <= '0;
         sample_valid <= 1'b0;
         short_frame  <= 1'b0;
         locked       <= 1'b0;
      end else begin
         bclk_s       <= {bclk_s[1:0], i2sBitClock};
         lr_s         <= {lr_s[0], i2sLeftRightSelect};
         sd_s         <= {sd_s[0], i2sSoundData};
         sample_valid <= latch_r;
         wdog         <= bclk_rise ? '0 : (wdog == TMAX ? wdog : wdog + 1'b1);
         if (bclk_rise) lr_prev <= lr;
         // bits past DATA_WIDTH are dropped; missing LSBs stay 0 (left-aligned)
         if (clr) begin
            cnt   <= '0;
            shreg <= '0;
         end else if (shift && cnt != FULL) begin
            cnt   <= cnt + 1'b1;
            shreg <= shreg | ({DATA_WIDTH{sd}} & (TOP >> cnt));
         end
         if (latch_l) begin
            left_hold  <= shreg;
            left_short <= cnt != FULL;
         end
         // both channels are published together so a half-updated pair is never visible
         if (latch_r) begin
            left_sample  <= left_hold;
            right_sample <= shreg;
            short_frame  <= left_short | (cnt != FULL);
            locked       <= 1'b1;
         end
         if (expired) locked <= 1'b0;
      end
   end
endmodule
